sar_scan_sequencer: RTL and testbench

Multi-channel scan controller sitting above the 8-bit SAR conversion core. It steps an analog input mux across the enabled channels and holds the sample switch closed for a programmable settle time. It then fires one conversion per channel, waits for the core's done flag and presents each result with its channel tag. It supports single-shot and continuous scanning, abort, and a done-timeout watchdog.

---
 rtl/sar_scan_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sar_scan_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan controller for the 8-bit SAR core: walks the enabled mux
// channels, settles, converts, and reports each result with its channel tag.
module sar_scan_sequencer #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int DW  = 8,
  parameter int SW  = 4,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  input  logic          abort,
  input  logic [NCH-1:0] ch_mask,
  input  logic [SW-1:0] settle,
  output logic          sar_start,
  input  logic          sar_done,
  input  logic [DW-1:0] sar_data,
  output logic [CW-1:0] mux_sel,
  output logic          sample,
  output logic [DW-1:0] res_data,
  output logic [CW-1:0] res_ch,
  output logic          res_valid,
  output logic          scan_done,
  output logic          busy,
  output logic          err
);

  localparam int TW = $clog2(TMO + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  logic [2:0]     state;
  logic [NCH-1:0] mask_q;
  logic [SW-1:0]  settle_q;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [CW-1:0]  cur_ch;
  logic           last_q;
  logic           higher_found;
  logic [CW-1:0]  higher_ch;
  logic [CW-1:0]  first_ch;
  logic           tmo_hit;

  function automatic logic [CW-1:0] lowest_bit(input logic [NCH-1:0] m);
    lowest_bit = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = CW'(i);
    end
  endfunction

  // Scanning downward leaves the lowest enabled channel above the current one.
  always_comb begin
    higher_found = 1'b0;
    higher_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_ch))) begin
        higher_found = 1'b1;
        higher_ch    = CW'(i);
      end
    end
  end

  assign first_ch = lowest_bit(mask_q);
  assign tmo_hit  = (tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      settle_q   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      cur_ch     <= '0;
      last_q     <= 1'b0;
      mux_sel    <= '0;
      sample     <= 1'b0;
      sar_start  <= 1'b0;
      res_data   <= '0;
      res_ch     <= '0;
      res_valid  <= 1'b0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      sar_start <= 1'b0;
      if ((state != S_IDLE) && abort) begin
        state  <= S_IDLE;
        sample <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (ch_mask != '0)) begin
              mask_q     <= ch_mask;
              settle_q   <= settle;
              err        <= 1'b0;
              cur_ch     <= lowest_bit(ch_mask);
              mux_sel    <= lowest_bit(ch_mask);
              settle_cnt <= '0;
              sample     <= 1'b1;
              busy       <= 1'b1;
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == settle_q) begin
              sample    <= 1'b0;
              sar_start <= 1'b1;
              state     <= S_CONV;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          S_CONV: begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
          // scan_done is decided here so it lines up with the last res_valid.
          S_WAIT: begin
            if (sar_done || tmo_hit) begin
              if (sar_done) begin
                res_data  <= sar_data;
                res_ch    <= cur_ch;
                res_valid <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              last_q    <= !higher_found;
              scan_done <= !higher_found;
              cur_ch    <= higher_found ? higher_ch : first_ch;
              state     <= S_NEXT;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_NEXT: begin
            if (last_q && !cont) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              mux_sel    <= cur_ch;
              settle_cnt <= '0;
              sample     <= 1'b1;
              state      <= S_SETTLE;
            end
          end
          default: begin
            state  <= S_IDLE;
            sample <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Directed bench for sar_scan_sequencer: a SAR core model answers conversions
// and a queue of expected result/end-of-scan events is checked as they appear.
module tb_sar_scan_sequencer;

  localparam int TMO       = 16;
  localparam int SAR_DELAY = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       abort;
  logic [3:0] ch_mask;
  logic [3:0] settle;
  logic       sar_start;
  logic       sar_done;
  logic [7:0] sar_data;
  logic [1:0] mux_sel;
  logic       sample;
  logic [7:0] res_data;
  logic [1:0] res_ch;
  logic       res_valid;
  logic       scan_done;
  logic       busy;
  logic       err;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic [1:0] ch;
    logic [7:0] data;
  } sb_entry_t;

  sb_entry_t  sb[$];
  int         checks = 0;
  int         failures = 0;
  int         silent_ch = -1;
  bit         model_en = 1'b1;
  bit         pend = 1'b0;
  int         pend_cnt = 0;
  logic [1:0] pend_ch = '0;
  int         sample_run = 0;
  int         chk_sample_w = 0;

  sar_scan_sequencer #(.NCH(4), .CW(2), .DW(8), .SW(4), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .ch_mask(ch_mask), .settle(settle), .sar_start(sar_start),
    .sar_done(sar_done), .sar_data(sar_data), .mux_sel(mux_sel),
    .sample(sample), .res_data(res_data), .res_ch(res_ch),
    .res_valid(res_valid), .scan_done(scan_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic v, input logic d, input logic [1:0] ch);
    sb_entry_t e;
    e.valid = v;
    e.done  = d;
    e.ch    = ch;
    e.data  = 8'hA0 + {6'b0, ch};
    sb.push_back(e);
  endtask

  // One clock: SAR core model, event scoreboard and sample-width tracking.
  task automatic tick();
    sb_entry_t e;
    @(negedge clk);
    if (sar_done) sar_done = 1'b0;
    if (model_en) begin
      if (sar_start) begin
        if (int'(mux_sel) != silent_ch) begin
          pend     = 1'b1;
          pend_cnt = SAR_DELAY;
          pend_ch  = mux_sel;
        end
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          sar_done = 1'b1;
          sar_data = 8'hA0 + {6'b0, pend_ch};
          pend     = 1'b0;
        end
      end
    end
    if (res_valid || scan_done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_event", 32'({res_valid, scan_done}), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("ev_res_valid", 32'(res_valid), 32'(e.valid));
        checkOutput("ev_scan_done", 32'(scan_done), 32'(e.done));
        if (e.valid) begin
          checkOutput("ev_res_ch", 32'(res_ch), 32'(e.ch));
          checkOutput("ev_res_data", 32'(res_data), 32'(e.data));
        end
      end
    end
    if (sample) begin
      sample_run++;
    end else begin
      if ((sample_run > 0) && (chk_sample_w > 0))
        checkOutput("sample_width", 32'(sample_run), 32'(chk_sample_w));
      sample_run = 0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] m, input logic [3:0] s, input logic c);
    ch_mask = m;
    settle  = s;
    cont    = c;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_sar_start(input int budget);
    int n = 0;
    while (!sar_start && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput("sar_start_seen", 32'(sar_start), 32'd1);
  endtask

  task automatic check_reset_values(input string p);
    checkOutput({p, "_mux_sel"}, 32'(mux_sel), 32'd0);
    checkOutput({p, "_sample"}, 32'(sample), 32'd0);
    checkOutput({p, "_sar_start"}, 32'(sar_start), 32'd0);
    checkOutput({p, "_res_data"}, 32'(res_data), 32'd0);
    checkOutput({p, "_res_ch"}, 32'(res_ch), 32'd0);
    checkOutput({p, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({p, "_scan_done"}, 32'(scan_done), 32'd0);
    checkOutput({p, "_busy"}, 32'(busy), 32'd0);
    checkOutput({p, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    ch_mask = '0; settle = '0; sar_done = 1'b0; sar_data = '0;
    tick();
    tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();

    $display("[TB] single scan mask=1011 settle=2");
    push_exp(1'b1, 1'b0, 2'd0);
    push_exp(1'b1, 1'b0, 2'd1);
    push_exp(1'b1, 1'b1, 2'd3);
    chk_sample_w = 3;
    applyStimulus(4'b1011, 4'd2, 1'b0);
    checkOutput("t1_sample_rise", 32'(sample), 32'd1);
    checkOutput("t1_busy_rise", 32'(busy), 32'd1);
    checkOutput("t1_mux_sel", 32'(mux_sel), 32'd0);
    drain(300);
    checkOutput("t1_busy_in_next", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    tick();
    checkOutput("t1_hold_ch", 32'(res_ch), 32'd3);
    checkOutput("t1_hold_data", 32'(res_data), 32'hA3);

    $display("[TB] continuous scan mask=0100");
    push_exp(1'b1, 1'b1, 2'd2);
    push_exp(1'b1, 1'b1, 2'd2);
    push_exp(1'b1, 1'b1, 2'd2);
    chk_sample_w = 2;
    applyStimulus(4'b0100, 4'd1, 1'b1);
    drain(300);
    push_exp(1'b1, 1'b1, 2'd2);
    wait_sar_start(50);
    cont = 1'b0;
    drain(100);
    tick();
    checkOutput("t2_busy_end", 32'(busy), 32'd0);
    repeat (30) tick();

    $display("[TB] timeout on ch 1");
    silent_ch = 1;
    push_exp(1'b1, 1'b0, 2'd0);
    push_exp(1'b0, 1'b1, 2'd1);
    chk_sample_w = 1;
    applyStimulus(4'b0011, 4'd0, 1'b0);
    wait_sar_start(20);
    tick();
    wait_sar_start(50);
    checkOutput("t3_err_at_start", 32'(err), 32'd0);
    repeat (TMO) tick();
    checkOutput("t3_err_before", 32'(err), 32'd0);
    tick();
    checkOutput("t3_err_set", 32'(err), 32'd1);
    checkOutput("t3_queue_empty", 32'(sb.size()), 32'd0);
    tick();
    checkOutput("t3_busy_end", 32'(busy), 32'd0);
    checkOutput("t3_err_sticky", 32'(err), 32'd1);
    checkOutput("t3_hold_data", 32'(res_data), 32'hA0);
    silent_ch = -1;

    $display("[TB] abort during WAIT with sar_done");
    model_en = 1'b0;
    chk_sample_w = 1;
    applyStimulus(4'b0001, 4'd0, 1'b0);
    checkOutput("t4_err_cleared", 32'(err), 32'd0);
    wait_sar_start(20);
    tick();
    tick();
    abort    = 1'b1;
    sar_done = 1'b1;
    sar_data = 8'h55;
    tick();
    abort = 1'b0;
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_sample", 32'(sample), 32'd0);
    checkOutput("t4_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t4_res_data_kept", 32'(res_data), 32'hA0);
    repeat (3) tick();
    model_en = 1'b1;
    push_exp(1'b1, 1'b1, 2'd0);
    chk_sample_w = 2;
    applyStimulus(4'b0001, 4'd1, 1'b0);
    drain(100);
    tick();
    checkOutput("t4_restart_busy_end", 32'(busy), 32'd0);

    $display("[TB] ignore cases");
    applyStimulus(4'b0000, 4'd2, 1'b0);
    checkOutput("t5_mask0_busy", 32'(busy), 32'd0);
    checkOutput("t5_mask0_sample", 32'(sample), 32'd0);
    push_exp(1'b1, 1'b1, 2'd0);
    chk_sample_w = 4;
    applyStimulus(4'b0001, 4'd3, 1'b0);
    applyStimulus(4'b1000, 4'd0, 1'b0);
    checkOutput("t5_busy_kept", 32'(busy), 32'd1);
    checkOutput("t5_mux_kept", 32'(mux_sel), 32'd0);
    sar_done = 1'b1;
    sar_data = 8'h77;
    tick();
    drain(100);
    tick();
    checkOutput("t5_busy_end", 32'(busy), 32'd0);
    checkOutput("t5_res_data", 32'(res_data), 32'hA0);

    $display("[TB] reset mid-SETTLE");
    chk_sample_w = 0;
    applyStimulus(4'b0010, 4'd5, 1'b0);
    tick();
    checkOutput("t6_sample_pre", 32'(sample), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("t6");
    pend = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t6_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
